stepper_axis: RTL
=================

STEPPER_AXIS -- requirements
Module: stepper_axis

Interface
REQ-001 SHALL have parameter STEP_W, default 32, width of signed step count.
REQ-002 SHALL have parameter SPEED_W, default 32, width of half-period value in clk cycles.
REQ-003 SHALL have parameter DIR_SETUP, default 4, clk cycles from dir valid to first step edge (range 0..255).
REQ-004 SHALL have ports:
  clk  input  1  sole clock, all state on rising edge.
  reset  input  1  asynchronous, active-high reset.
  stepper_step_in  input  STEP_W  signed two's-complement move; sign selects dir.
  stepper_speed  input  SPEED_W  cruise half-period in clk cycles.
  stepper_enable  input  1  channel enable; low aborts motion.
  start_driving  input  1  level; rising edge requests a move.
  step_signal  output  1  step pulse to driver.
  dir  output  1  direction, 1 = negative move.
  stepper_driving  output  1  high while a move is active.
  move_done  output  1  one-cycle pulse at normal completion.
  move_aborted  output  1  one-cycle pulse at abort.
  stepper_step_out  output  STEP_W  signed steps remaining, sign = dir.

Function
REQ-005 SHALL detect start as start_driving high while its registered copy is low; level-held start SHALL NOT retrigger.
REQ-006 SHALL accept start only in IDLE with stepper_enable=1 and stepper_step_in not 0 and not -2^(STEP_W-1); otherwise ignore it, no pulses, no status pulse.
REQ-007 SHALL on accepted start at edge t latch magnitude, sign and speed (speed 0 treated as 1); dir, stepper_driving=1 and stepper_step_out=input valid from t+1.
REQ-008 SHALL use states IDLE, SETUP, HIGH, LOW; IDLE->SETUP on accept; SETUP lasts DIR_SETUP cycles (0 = skip); SETUP->HIGH; HIGH->LOW; LOW->HIGH; HIGH->IDLE after last step.
REQ-009 SHALL hold step_signal=1 exactly in HIGH; HIGH and LOW each last the current period P cycles; first rising step edge at t+1+DIR_SETUP.
REQ-010 SHALL decrement remaining magnitude by 1 on each HIGH exit; stepper_step_out SHALL track it with latched sign.
REQ-011 SHALL on final HIGH exit go IDLE, drop stepper_driving, pulse move_done, present stepper_step_out=0; final LOW phase omitted.
REQ-012 SHALL keep dir constant from t+1 until next accepted start; dir and stepper_step_out hold after move end.
REQ-013 SHALL abort on stepper_enable=0 in SETUP/HIGH/LOW: next cycle step_signal=0, stepper_driving=0, IDLE, move_aborted pulse, stepper_step_out = signed remaining (step in HIGH at abort not counted).
REQ-014 SHALL give abort priority over completion when both occur the same cycle.
REQ-015 SHALL ignore stepper_speed and stepper_step_in changes while not IDLE.
REQ-016 SHALL make start edge coincident with completion cycle non-accepted; new edge required.

Reset
REQ-017 SHALL on reset force IDLE; step_signal=0, dir=0, stepper_driving=0, move_done=0, move_aborted=0, stepper_step_out=0, start edge register=0, all counters 0.
REQ-018 SHALL on reset mid-move drop step_signal immediately (asynchronously) with no status pulse.

Configuration
REQ-019 SHALL, with STEPPER_AXIS_RAMP_EN defined, add parameter RAMP_START (default 1000) and input accel_dec (SPEED_W): P starts at max(RAMP_START, speed), decreases by accel_dec per step, floored at speed; when remaining <= steps spent accelerating, P increases by accel_dec per step, capped at start value.
REQ-020 SHALL, without STEPPER_AXIS_RAMP_EN, omit accel_dec and RAMP_START, P = latched speed throughout.

Structure
REQ-021 SHALL place state encoding and phase constants in shared package stepper_pkg.
REQ-022 SHALL implement period calculation in sub-module stepper_ramp (constant period when ramp disabled).

Verification
REQ-023 Move +3, speed 2, DIR_SETUP 4: start at t -> dir=0 at t+1, steps rise t+5, t+9, t+13, each 2 high; move_done at final HIGH exit; out 3,2,1,0.
REQ-024 Move -2, speed 1: dir=1 at t+1, two 1-cycle pulses, stepper_step_out -2,-1,0, move_done once.
REQ-025 Move +10, speed 3, enable low during 4th HIGH: step_signal low next cycle, move_aborted pulse, stepper_step_out=+7.
REQ-026 start held high 100 cycles, move +1: exactly one pulse; stepper_step_in 0 or -2^31: no pulse, no status.
REQ-027 Reset asserted in HIGH of move +5: step_signal=0 immediately, all outputs 0, next start edge accepted normally.
REQ-028 RAMP_EN, RAMP_START 10, speed 4, accel_dec 2, move +8: periods 10,8,6,4,4,6,8,10.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared state encoding and phase constants for the stepper axis.
package stepper_pkg;
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  // Shortest legal phase; a programmed speed of 0 is promoted to this.
  localparam int MIN_PERIOD = 1;
endpackage

// File: rtl/stepper_ramp.sv
// Per-step phase length. STEPPER_AXIS_RAMP_EN adds a trapezoidal accel/decel
// profile; otherwise the period is the speed latched at move start.
module stepper_ramp
  import stepper_pkg::*;
#(
  parameter int SPEED_W = 32,
  parameter int STEP_W  = 32
`ifdef STEPPER_AXIS_RAMP_EN
  , parameter int RAMP_START = 1000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               adv,
  input  logic [SPEED_W-1:0] speed,
  input  logic [STEP_W-1:0]  remaining,
`ifdef STEPPER_AXIS_RAMP_EN
  input  logic [SPEED_W-1:0] accel_dec,
`endif
  output logic [SPEED_W-1:0] period
);
`ifdef STEPPER_AXIS_RAMP_EN
  logic [SPEED_W-1:0] floor_p, top_p, acc, start_p;
  logic [STEP_W-1:0]  spent;
  logic [SPEED_W:0]   dec_lim, inc_sum;

  assign start_p = (speed > SPEED_W'(RAMP_START)) ? speed : SPEED_W'(RAMP_START);
  assign dec_lim = {1'b0, floor_p} + {1'b0, acc};
  assign inc_sum = {1'b0, period} + {1'b0, acc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period  <= '0;
      floor_p <= '0;
      top_p   <= '0;
      acc     <= '0;
      spent   <= '0;
    end else if (load) begin
      period  <= start_p;
      top_p   <= start_p;
      floor_p <= speed;
      acc     <= accel_dec;
      spent   <= '0;
    end else if (adv) begin
      // Decelerate once the steps left fit inside the accel ramp just used.
      if (remaining <= spent)
        period <= (inc_sum >= {1'b0, top_p}) ? top_p : inc_sum[SPEED_W-1:0];
      else if (period > floor_p) begin
        period <= ({1'b0, period} > dec_lim) ? period - acc : floor_p;
        spent  <= spent + STEP_W'(1);
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{adv, remaining};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     period <= '0;
    else if (load) period <= speed;
  end
`endif
endmodule

// File: rtl/stepper_axis.sv
// Single-axis step/dir generator with direction setup, abort and status pulses.
// Optional ramping profile enabled by defining STEPPER_AXIS_RAMP_EN.
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int STEP_W    = 32,
  parameter int SPEED_W   = 32,
  parameter int DIR_SETUP = 4
`ifdef STEPPER_AXIS_RAMP_EN
  , parameter int RAMP_START = 1000
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [STEP_W-1:0] stepper_step_in,
  input  logic [SPEED_W-1:0]       stepper_speed,
  input  logic                     stepper_enable,
  input  logic                     start_driving,
`ifdef STEPPER_AXIS_RAMP_EN
  input  logic [SPEED_W-1:0]       accel_dec,
`endif
  output logic                     step_signal,
  output logic                     dir,
  output logic                     stepper_driving,
  output logic                     move_done,
  output logic                     move_aborted,
  output logic signed [STEP_W-1:0] stepper_step_out
);
  state_t             state;
  logic [SPEED_W-1:0] cnt, period, speed_eff;
  logic [STEP_W-1:0]  rem, mag;
  logic               neg, start_q;
  logic               accept, step_ok, phase_last, setup_last, ramp_adv;

  assign step_ok    = (stepper_step_in != '0) &&
                      (stepper_step_in != {1'b1, {(STEP_W-1){1'b0}}});
  assign accept     = (state == ST_IDLE) && start_driving && !start_q &&
                      stepper_enable && step_ok;
  assign mag        = stepper_step_in[STEP_W-1] ? $unsigned(-stepper_step_in)
                                                : $unsigned(stepper_step_in);
  assign speed_eff  = (stepper_speed == '0) ? SPEED_W'(MIN_PERIOD) : stepper_speed;
  assign phase_last = (cnt == period - SPEED_W'(1));
  assign setup_last = (cnt == SPEED_W'(DIR_SETUP - 1));
  assign ramp_adv   = (state == ST_LOW) && phase_last && stepper_enable;

  // Derived straight from state so reset drops the pulse without a clock.
  assign step_signal      = (state == ST_HIGH);
  assign stepper_driving  = (state != ST_IDLE);
  assign dir              = neg;
  assign stepper_step_out = neg ? -$signed(rem) : $signed(rem);

  stepper_ramp #(
    .SPEED_W   (SPEED_W),
    .STEP_W    (STEP_W)
`ifdef STEPPER_AXIS_RAMP_EN
    , .RAMP_START(RAMP_START)
`endif
  ) u_ramp (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .adv       (ramp_adv),
    .speed     (speed_eff),
    .remaining (rem),
`ifdef STEPPER_AXIS_RAMP_EN
    .accel_dec (accel_dec),
`endif
    .period    (period)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rem          <= '0;
      neg          <= 1'b0;
      start_q      <= 1'b0;
      move_done    <= 1'b0;
      move_aborted <= 1'b0;
    end else begin
      start_q      <= start_driving;
      move_done    <= 1'b0;
      move_aborted <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          neg   <= stepper_step_in[STEP_W-1];
          rem   <= mag;
          cnt   <= '0;
          state <= (DIR_SETUP == 0) ? ST_HIGH : ST_SETUP;
        end
      end else if (!stepper_enable) begin
        // Abort wins over a completion landing in the same cycle.
        state        <= ST_IDLE;
        cnt          <= '0;
        move_aborted <= 1'b1;
      end else begin
        cnt <= cnt + SPEED_W'(1);
        case (state)
          ST_SETUP: if (setup_last) begin
            cnt   <= '0;
            state <= ST_HIGH;
          end
          ST_HIGH: if (phase_last) begin
            cnt <= '0;
            rem <= rem - STEP_W'(1);
            if (rem == STEP_W'(1)) begin
              state     <= ST_IDLE;
              move_done <= 1'b1;
            end else begin
              state <= ST_LOW;
            end
          end
          ST_LOW: if (phase_last) begin
            cnt   <= '0;
            state <= ST_HIGH;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
